// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and widths, also used for register_renamer preg widths.
package rob_pkg;

    localparam int unsigned ROB_NUM_A_REGS = 32;
    localparam int unsigned ROB_NUM_P_REGS = 64;
    localparam int unsigned ROB_NUM_ENTRIES = 16;

    localparam int unsigned ARCH_W = $clog2(ROB_NUM_A_REGS);
    localparam int unsigned PREG_W = $clog2(ROB_NUM_P_REGS);
    localparam int unsigned TAG_W  = $clog2(ROB_NUM_ENTRIES);
    localparam int unsigned CNT_W  = TAG_W + 1;

    // One in-flight instruction awaiting in-order retirement.
    typedef struct packed {
        logic              valid;
        logic              done;
        logic              has_dest;
        logic [ARCH_W-1:0] arch_dest;
        logic [PREG_W-1:0] p_dest;
        logic [PREG_W-1:0] old_dest;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Two-wide allocate / two-port complete / two-wide in-order retire reorder buffer.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int unsigned NUM_A_REGS = ROB_NUM_A_REGS,
    parameter int unsigned NUM_P_REGS = ROB_NUM_P_REGS,
    parameter int unsigned ROB_DEPTH  = ROB_NUM_ENTRIES
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            alloc_en0_i,
    input  logic                            alloc_en1_i,
    input  logic [$clog2(NUM_A_REGS)-1:0]   arch_dest0_i,
    input  logic [$clog2(NUM_A_REGS)-1:0]   arch_dest1_i,
    input  logic [$clog2(NUM_P_REGS)-1:0]   p_dest0_i,
    input  logic [$clog2(NUM_P_REGS)-1:0]   p_dest1_i,
    input  logic [$clog2(NUM_P_REGS)-1:0]   old_dest0_i,
    input  logic [$clog2(NUM_P_REGS)-1:0]   old_dest1_i,
    input  logic                            has_dest0_i,
    input  logic                            has_dest1_i,
    output logic [$clog2(ROB_DEPTH)-1:0]    rob_tag0_o,
    output logic [$clog2(ROB_DEPTH)-1:0]    rob_tag1_o,
    output logic                            full_o,
    output logic                            empty_o,
    input  logic                            complete_en0_i,
    input  logic                            complete_en1_i,
    input  logic [$clog2(ROB_DEPTH)-1:0]    complete_tag0_i,
    input  logic [$clog2(ROB_DEPTH)-1:0]    complete_tag1_i,
    output logic                            en_free_reg0_o,
    output logic                            en_free_reg1_o,
    output logic [$clog2(NUM_P_REGS)-1:0]   free_reg0_o,
    output logic [$clog2(NUM_P_REGS)-1:0]   free_reg1_o,
    output logic                            retire0_o,
    output logic                            retire1_o,
    output logic [$clog2(NUM_A_REGS)-1:0]   retire_arch0_o,
    output logic [$clog2(NUM_A_REGS)-1:0]   retire_arch1_o,
    output logic [$clog2(NUM_P_REGS)-1:0]   retire_preg0_o,
    output logic [$clog2(NUM_P_REGS)-1:0]   retire_preg1_o
);

    localparam int unsigned AW = $clog2(NUM_A_REGS);
    localparam int unsigned PW = $clog2(NUM_P_REGS);
    localparam int unsigned TW = $clog2(ROB_DEPTH);
    localparam int unsigned CW = TW + 1;
    localparam logic [CW-1:0] FULL_THRESH = CW'(ROB_DEPTH - 2);

    rob_entry_t      entries [ROB_DEPTH];
    logic [TW-1:0]   head;
    logic [TW-1:0]   tail;
    logic [CW-1:0]   count;

    logic            acc0;
    logic            acc1;
    logic [TW-1:0]   head1;
    logic [1:0]      n_alloc;
    logic [1:0]      n_ret;

    // Occupancy flags, accepted allocations and tag assignment.
    always_comb begin
        full_o     = (count > FULL_THRESH);
        empty_o    = (count == '0);
        acc0       = alloc_en0_i & ~full_o;
        acc1       = alloc_en1_i & ~full_o;
        rob_tag0_o = tail;
        rob_tag1_o = tail + TW'(alloc_en0_i);
        n_alloc    = 2'(acc0) + 2'(acc1);
    end

    // In-order retire of head and head+1, data forced to zero when not retiring.
    always_comb begin
        head1          = head + TW'(1);
        retire0_o      = entries[head].valid & entries[head].done;
        retire1_o      = retire0_o & entries[head1].valid & entries[head1].done;
        n_ret          = 2'(retire0_o) + 2'(retire1_o);

        en_free_reg0_o = retire0_o & entries[head].has_dest;
        en_free_reg1_o = retire1_o & entries[head1].has_dest;
        free_reg0_o    = retire0_o ? PW'(entries[head].old_dest)   : '0;
        free_reg1_o    = retire1_o ? PW'(entries[head1].old_dest)  : '0;
        retire_arch0_o = retire0_o ? AW'(entries[head].arch_dest)  : '0;
        retire_arch1_o = retire1_o ? AW'(entries[head1].arch_dest) : '0;
        retire_preg0_o = retire0_o ? PW'(entries[head].p_dest)     : '0;
        retire_preg1_o = retire1_o ? PW'(entries[head1].p_dest)    : '0;
    end

    // Entry array and pointers; later writes (retire clear, allocate) take priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < int'(ROB_DEPTH); i++) begin
                entries[i].valid <= 1'b0;
                entries[i].done  <= 1'b0;
            end
        end else begin
            if (complete_en0_i && entries[complete_tag0_i].valid) begin
                entries[complete_tag0_i].done <= 1'b1;
            end
            if (complete_en1_i && entries[complete_tag1_i].valid) begin
                entries[complete_tag1_i].done <= 1'b1;
            end

            if (retire0_o) begin
                entries[head].valid <= 1'b0;
                entries[head].done  <= 1'b0;
            end
            if (retire1_o) begin
                entries[head1].valid <= 1'b0;
                entries[head1].done  <= 1'b0;
            end

            if (acc0) begin
                entries[tail] <= '{valid: 1'b1, done: 1'b0, has_dest: has_dest0_i,
                                   arch_dest: ARCH_W'(arch_dest0_i),
                                   p_dest: PREG_W'(p_dest0_i),
                                   old_dest: PREG_W'(old_dest0_i)};
            end
            if (acc1) begin
                entries[rob_tag1_o] <= '{valid: 1'b1, done: 1'b0, has_dest: has_dest1_i,
                                         arch_dest: ARCH_W'(arch_dest1_i),
                                         p_dest: PREG_W'(p_dest1_i),
                                         old_dest: PREG_W'(old_dest1_i)};
            end

            head  <= head + TW'(n_ret);
            tail  <= tail + TW'(n_alloc);
            count <= count + CW'(n_alloc) - CW'(n_ret);
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a queue-based program-order model.
module tb_reorder_buffer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       alloc_en0_i, alloc_en1_i;
    logic [4:0] arch_dest0_i, arch_dest1_i;
    logic [5:0] p_dest0_i, p_dest1_i, old_dest0_i, old_dest1_i;
    logic       has_dest0_i, has_dest1_i;
    logic [3:0] rob_tag0_o, rob_tag1_o;
    logic       full_o, empty_o;
    logic       complete_en0_i, complete_en1_i;
    logic [3:0] complete_tag0_i, complete_tag1_i;
    logic       en_free_reg0_o, en_free_reg1_o;
    logic [5:0] free_reg0_o, free_reg1_o;
    logic       retire0_o, retire1_o;
    logic [4:0] retire_arch0_o, retire_arch1_o;
    logic [5:0] retire_preg0_o, retire_preg1_o;

    int checks = 0;
    int errors = 0;

    reorder_buffer dut (
        .clk_i(clk), .rst_i(rst_i),
        .alloc_en0_i(alloc_en0_i), .alloc_en1_i(alloc_en1_i),
        .arch_dest0_i(arch_dest0_i), .arch_dest1_i(arch_dest1_i),
        .p_dest0_i(p_dest0_i), .p_dest1_i(p_dest1_i),
        .old_dest0_i(old_dest0_i), .old_dest1_i(old_dest1_i),
        .has_dest0_i(has_dest0_i), .has_dest1_i(has_dest1_i),
        .rob_tag0_o(rob_tag0_o), .rob_tag1_o(rob_tag1_o),
        .full_o(full_o), .empty_o(empty_o),
        .complete_en0_i(complete_en0_i), .complete_en1_i(complete_en1_i),
        .complete_tag0_i(complete_tag0_i), .complete_tag1_i(complete_tag1_i),
        .en_free_reg0_o(en_free_reg0_o), .en_free_reg1_o(en_free_reg1_o),
        .free_reg0_o(free_reg0_o), .free_reg1_o(free_reg1_o),
        .retire0_o(retire0_o), .retire1_o(retire1_o),
        .retire_arch0_o(retire_arch0_o), .retire_arch1_o(retire_arch1_o),
        .retire_preg0_o(retire_preg0_o), .retire_preg1_o(retire_preg1_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Program-order model: one queue element per in-flight instruction.
    typedef struct {
        int tag;
        bit done;
        bit has;
        int arch;
        int pdest;
        int old;
    } m_t;

    m_t mq[$];
    int next_tag = 0;
    bit model_ok = 0;

    always @(posedge clk) begin
        if (rst_i) begin
            mq.delete();
            next_tag = 0;
            model_ok = 1;
        end else if (model_ok) begin
            int  nret;
            bit  was_full;
            m_t  e;
            nret = 0;
            if (mq.size() > 0 && mq[0].done) begin
                nret = 1;
                if (mq.size() > 1 && mq[1].done) nret = 2;
            end
            was_full = (mq.size() >= DEPTH - 1);
            for (int k = 0; k < mq.size(); k++) begin
                if (complete_en0_i && mq[k].tag == int'(complete_tag0_i)) mq[k].done = 1;
                if (complete_en1_i && mq[k].tag == int'(complete_tag1_i)) mq[k].done = 1;
            end
            repeat (nret) void'(mq.pop_front());
            if (!was_full) begin
                if (alloc_en0_i) begin
                    e = '{next_tag, 0, has_dest0_i, int'(arch_dest0_i), int'(p_dest0_i), int'(old_dest0_i)};
                    mq.push_back(e);
                    next_tag = (next_tag + 1) % DEPTH;
                end
                if (alloc_en1_i) begin
                    e = '{next_tag, 0, has_dest1_i, int'(arch_dest1_i), int'(p_dest1_i), int'(old_dest1_i)};
                    mq.push_back(e);
                    next_tag = (next_tag + 1) % DEPTH;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (model_ok && !rst_i) begin
            bit r0, r1;
            r0 = (mq.size() > 0) && mq[0].done;
            r1 = r0 && (mq.size() > 1) && mq[1].done;
            chk("m_full",  full_o,  32'(mq.size() >= DEPTH - 1));
            chk("m_empty", empty_o, 32'(mq.size() == 0));
            chk("m_tag0",  rob_tag0_o, 32'(next_tag));
            chk("m_tag1",  rob_tag1_o, 32'((next_tag + int'(alloc_en0_i)) % DEPTH));
            chk("m_ret0",  retire0_o, 32'(r0));
            chk("m_ret1",  retire1_o, 32'(r1));
            chk("m_enf0",  en_free_reg0_o, 32'(r0 && mq[0].has));
            chk("m_enf1",  en_free_reg1_o, 32'(r1 && mq[1].has));
            chk("m_free0", free_reg0_o,    r0 ? 32'(mq[0].old)   : 32'd0);
            chk("m_free1", free_reg1_o,    r1 ? 32'(mq[1].old)   : 32'd0);
            chk("m_arch0", retire_arch0_o, r0 ? 32'(mq[0].arch)  : 32'd0);
            chk("m_arch1", retire_arch1_o, r1 ? 32'(mq[1].arch)  : 32'd0);
            chk("m_preg0", retire_preg0_o, r0 ? 32'(mq[0].pdest) : 32'd0);
            chk("m_preg1", retire_preg1_o, r1 ? 32'(mq[1].pdest) : 32'd0);
        end
    end

    task automatic idle();
        alloc_en0_i = 0; alloc_en1_i = 0;
        arch_dest0_i = '0; arch_dest1_i = '0;
        p_dest0_i = '0; p_dest1_i = '0;
        old_dest0_i = '0; old_dest1_i = '0;
        has_dest0_i = 0; has_dest1_i = 0;
        complete_en0_i = 0; complete_en1_i = 0;
        complete_tag0_i = '0; complete_tag1_i = '0;
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a0(input int arch, input int pd, input int od, input bit has);
        alloc_en0_i = 1; arch_dest0_i = 5'(arch); p_dest0_i = 6'(pd);
        old_dest0_i = 6'(od); has_dest0_i = has;
    endtask

    task automatic set_a1(input int arch, input int pd, input int od, input bit has);
        alloc_en1_i = 1; arch_dest1_i = 5'(arch); p_dest1_i = 6'(pd);
        old_dest1_i = 6'(od); has_dest1_i = has;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n;
        n = 0;
        while (empty_o !== 1'b1 && n < budget) begin
            go();
            n++;
        end
        chk(name, empty_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_tail;
        int pt0, pn;
        idle();
        rst_i = 1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 0;
        @(negedge clk);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_ret0", retire0_o, 0);
        chk("rst_tag0", rob_tag0_o, 0);

        // Two allocations take tags 0 and 1.
        go();
        set_a0(1, 32, 1, 1);
        set_a1(2, 33, 2, 1);
        @(negedge clk);
        chk("alloc_tag0", rob_tag0_o, 0);
        chk("alloc_tag1", rob_tag1_o, 1);
        chk("empty_same_cycle", empty_o, 1);
        go(); idle();
        @(negedge clk);
        chk("empty_after_alloc", empty_o, 0);
        chk("no_retire_yet", retire0_o, 0);

        // Younger completes first: nothing retires.
        go();
        complete_en1_i = 1; complete_tag1_i = 4'd1;
        go(); idle();
        @(negedge clk);
        chk("young_only_ret0", retire0_o, 0);

        // Older completes: both retire together.
        go();
        complete_en0_i = 1; complete_tag0_i = 4'd0;
        go(); idle();
        @(negedge clk);
        chk("pair_ret0", retire0_o, 1);
        chk("pair_ret1", retire1_o, 1);
        chk("pair_free0", free_reg0_o, 1);
        chk("pair_free1", free_reg1_o, 2);
        chk("pair_preg1", retire_preg1_o, 33);
        go();
        @(negedge clk);
        chk("pair_empty_after", empty_o, 1);

        // Instruction without a destination retires without freeing.
        go();
        set_a0(0, 0, 5, 0);
        go(); idle();
        complete_en0_i = 1; complete_tag0_i = 4'd2;
        go(); idle();
        @(negedge clk);
        chk("nodest_ret0", retire0_o, 1);
        chk("nodest_enf0", en_free_reg0_o, 0);
        chk("nodest_ret1", retire1_o, 0);
        go();

        // Fill to 14 entries (tags 3..0): still not full.
        for (int k = 0; k < 7; k++) begin
            idle();
            set_a0(k + 3, 40 + 2 * k, 10 + 2 * k, 1);
            set_a1(k + 4, 41 + 2 * k, 11 + 2 * k, 1);
            go();
        end
        idle();
        @(negedge clk);
        chk("fill14_full", full_o, 0);
        chk("fill14_tag0", rob_tag0_o, 1);
        go();
        set_a0(20, 60, 30, 1);
        go(); idle();
        @(negedge clk);
        chk("fill15_full", full_o, 1);
        go();
        set_a0(21, 61, 31, 1);
        set_a1(22, 62, 32, 1);
        @(negedge clk);
        chk("full_tag0", rob_tag0_o, 2);
        go(); idle();
        @(negedge clk);
        chk("ignored_tag0", rob_tag0_o, 2);
        chk("ignored_full", full_o, 1);

        // Retire two: full drops only after the edge.
        go();
        complete_en0_i = 1; complete_tag0_i = 4'd3;
        complete_en1_i = 1; complete_tag1_i = 4'd4;
        go(); idle();
        @(negedge clk);
        chk("full_ret1", retire1_o, 1);
        chk("full_same_cycle", full_o, 1);
        go();
        @(negedge clk);
        chk("full_released", full_o, 0);

        // Drain tags 5..15,0,1.
        go();
        for (int t = 5; t < 18; t += 2) begin
            idle();
            complete_en0_i = 1; complete_tag0_i = 4'(t % DEPTH);
            if (t + 1 < 18) begin
                complete_en1_i = 1; complete_tag1_i = 4'((t + 1) % DEPTH);
            end
            go();
        end
        idle();
        wait_empty("drain1_empty", 40);

        // Streaming with wrap; first allocation is a lone slot 1.
        exp_tail = 2;
        pn = 0;
        pt0 = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (i != 0) set_a0((i * 3 + 1) % 32, 32 + (i * 5) % 32, (i * 7 + 3) % 64, (i % 5) != 0);
            set_a1((i * 3 + 2) % 32, 32 + (i * 5 + 1) % 32, (i * 7 + 4) % 64, (i % 4) != 1);
            if (pn >= 1) begin complete_en0_i = 1; complete_tag0_i = 4'(pt0); end
            if (pn == 2) begin complete_en1_i = 1; complete_tag1_i = 4'((pt0 + 1) % DEPTH); end
            if (i == 0) begin
                @(negedge clk);
                chk("lone1_tag1", rob_tag1_o, 2);
            end
            if (i == 7) begin
                @(negedge clk);
                chk("wrap_tag0", rob_tag0_o, 15);
                chk("wrap_tag1", rob_tag1_o, 0);
            end
            pt0 = exp_tail;
            pn = (i == 0) ? 1 : 2;
            exp_tail = (exp_tail + pn) % DEPTH;
            go();
        end
        idle();
        complete_en0_i = 1; complete_tag0_i = 4'(pt0);
        complete_en1_i = 1; complete_tag1_i = 4'((pt0 + 1) % DEPTH);
        go(); idle();
        wait_empty("drain2_empty", 40);

        // Completion on an empty ROB is ignored.
        go();
        complete_en0_i = 1; complete_tag0_i = 4'd3;
        go(); idle();
        @(negedge clk);
        chk("stray_empty", empty_o, 1);
        chk("stray_ret0", retire0_o, 0);

        // Reset with five in flight overrides same-cycle activity.
        go();
        set_a0(1, 40, 7, 1); set_a1(2, 41, 8, 1);
        go(); idle();
        set_a0(3, 42, 9, 1); set_a1(4, 43, 10, 1);
        go(); idle();
        set_a0(5, 44, 11, 1);
        go(); idle();
        @(negedge clk);
        chk("inflight_empty", empty_o, 0);
        go();
        rst_i = 1;
        set_a0(6, 45, 12, 1); set_a1(7, 46, 13, 1);
        complete_en0_i = 1; complete_tag0_i = 4'(exp_tail);
        go(); idle();
        rst_i = 0;
        @(negedge clk);
        chk("rst2_empty", empty_o, 1);
        chk("rst2_full", full_o, 0);
        chk("rst2_tag0", rob_tag0_o, 0);
        chk("rst2_ret0", retire0_o, 0);
        go();
        go();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
